// File: rtl/apu_dispatch_pkg.sv
// apu_dispatch_pkg: APU core widths, ring entry and dispatch FSM state types
// shared by the APU dispatch slice.
package apu_dispatch_pkg;
   localparam int NARGS    = 3;
   localparam int WOP      = 8;
   localparam int NDSFLAGS = 15;
   localparam int NUSFLAGS = 5;
   localparam int NRS      = 3;
   localparam int RW       = 5;
   localparam int DW       = 32;

   typedef struct packed {
      logic [RW-1:0]       rd;
      logic [DW-1:0]       data;
      logic [NUSFLAGS-1:0] flags;
      logic                filled;
   } entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // One extra pointer bit separates full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/apu_dispatch_if.sv
// apu_dispatch_if: issue, APU request/response and writeback channels of the
// APU dispatcher; slave is the dispatcher view, master the core/FPU side.
interface apu_dispatch_if;
   import apu_dispatch_pkg::*;

   logic                           issue_valid_i;
   logic                           issue_ready_o;
   logic [NARGS-1:0][DW-1:0]       issue_operands_i;
   logic [WOP-1:0]                 issue_op_i;
   logic [NDSFLAGS-1:0]            issue_flags_i;
   logic [RW-1:0]                  issue_rd_i;
   logic [NRS-1:0][RW-1:0]         issue_rs_i;
   logic [NRS-1:0]                 issue_rs_use_i;

   logic                           apu_req_o;
   logic                           apu_gnt_i;
   logic [NARGS-1:0][DW-1:0]       apu_operands_o;
   logic [WOP-1:0]                 apu_op_o;
   logic [NDSFLAGS-1:0]            apu_flags_o;
   logic                           apu_rvalid_i;
   logic [DW-1:0]                  apu_rdata_i;
   logic [NUSFLAGS-1:0]            apu_rflags_i;

   logic                           wb_valid_o;
   logic                           wb_ready_i;
   logic [RW-1:0]                  wb_rd_o;
   logic [DW-1:0]                  wb_data_o;
   logic [NUSFLAGS-1:0]            wb_flags_o;

   modport slave (
      input  issue_valid_i, issue_operands_i, issue_op_i, issue_flags_i,
             issue_rd_i, issue_rs_i, issue_rs_use_i,
             apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i, wb_ready_i,
      output issue_ready_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
             wb_valid_o, wb_rd_o, wb_data_o, wb_flags_o
   );

   modport master (
      output issue_valid_i, issue_operands_i, issue_op_i, issue_flags_i,
             issue_rd_i, issue_rs_i, issue_rs_use_i,
             apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i, wb_ready_i,
      input  issue_ready_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
             wb_valid_o, wb_rd_o, wb_data_o, wb_flags_o
   );
endinterface

// File: rtl/apu_dispatch_ring.sv
// apu_dispatch_ring: in-order slot ring for in-flight APU operations with
// alloc (issue), fill (FPU response) and head (writeback) pointers.
module apu_dispatch_ring
   import apu_dispatch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = ptr_width(DEPTH)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     issue_en,
   input  logic [RW-1:0]            issue_rd,
   input  logic                     fill_en,
   input  logic [DW-1:0]            fill_data,
   input  logic [NUSFLAGS-1:0]      fill_flags,
   input  logic                     wb_en,
   input  logic                     flush_en,
   output logic [PW-1:0]            count,
   output logic [PW-1:0]            inflight,
   output entry_t                   head_entry,
   output logic                     wb_valid,
   output logic [DEPTH-1:0]         live,
   output logic [DEPTH-1:0][RW-1:0] live_rd
);
   localparam int AW = PW - 1;

   entry_t         mem [DEPTH];
   logic [PW-1:0]  alloc_ptr;
   logic [PW-1:0]  fill_ptr;
   logic [PW-1:0]  head_ptr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (issue_en) begin
            mem[alloc_ptr[AW-1:0]].rd     <= issue_rd;
            mem[alloc_ptr[AW-1:0]].filled <= 1'b0;
            alloc_ptr <= alloc_ptr + PW'(1);
         end
         if (fill_en) begin
            mem[fill_ptr[AW-1:0]].data   <= fill_data;
            mem[fill_ptr[AW-1:0]].flags  <= fill_flags;
            mem[fill_ptr[AW-1:0]].filled <= 1'b1;
            fill_ptr <= fill_ptr + PW'(1);
         end
         // A flush drops every tracked slot; late responses are counted upstream.
         if (flush_en) begin
            fill_ptr <= alloc_ptr;
            head_ptr <= alloc_ptr;
         end else if (wb_en) begin
            head_ptr <= head_ptr + PW'(1);
         end
      end
   end

   assign count      = alloc_ptr - head_ptr;
   assign inflight   = alloc_ptr - fill_ptr;
   assign head_entry = mem[head_ptr[AW-1:0]];
   assign wb_valid   = (head_ptr != alloc_ptr) && head_entry.filled;

   always_comb begin
      logic [AW-1:0] off;
      off     = '0;
      live    = '0;
      live_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = AW'(i) - head_ptr[AW-1:0];
         live[i]    = {1'b0, off} < count;
         live_rd[i] = mem[i].rd;
      end
   end
endmodule

// File: rtl/apu_dispatch.sv
// apu_dispatch: core-side APU initiator with in-order result tracking and
// flush drain. APU_DISPATCH_HAZARD_EN enables the RAW stall on live rd.
//
// state | meaning
// RUN   | normal issue, fill and writeback
// DRAIN | post-flush: discard drop_cnt late FPU responses, no issue
module apu_dispatch
   import apu_dispatch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   apu_dispatch_if.slave bus
);
   localparam int PW = ptr_width(DEPTH);

   state_e                    state;
   logic [PW-1:0]             drop_cnt;
   logic [PW-1:0]             count;
   logic [PW-1:0]             inflight;
   logic [PW-1:0]             net_inflight;
   logic                      hazard;
   logic                      can_accept;
   logic                      fill_en;
   logic                      issue_fire;
   logic                      wb_valid;
   logic                      wb_fire;
   entry_t                    head_entry;
   logic [DEPTH-1:0]          live;
   logic [DEPTH-1:0][RW-1:0]  live_rd;
   logic                      unused_ok;

   assign fill_en      = bus.apu_rvalid_i && (state == RUN) && (inflight != '0);
   assign net_inflight = inflight - PW'(fill_en);
   assign can_accept   = (state == RUN) && (count < PW'(DEPTH)) && !hazard;
   assign bus.apu_req_o     = bus.issue_valid_i && can_accept && !flush_i;
   assign issue_fire        = bus.apu_req_o && bus.apu_gnt_i;
   assign bus.issue_ready_o = issue_fire;
   assign wb_fire           = wb_valid && bus.wb_ready_i;

   assign bus.apu_operands_o = bus.issue_operands_i;
   assign bus.apu_op_o       = bus.issue_op_i;
   assign bus.apu_flags_o    = bus.issue_flags_i;

   apu_dispatch_ring #(.DEPTH(DEPTH)) u_ring (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .issue_en   (issue_fire),
      .issue_rd   (bus.issue_rd_i),
      .fill_en    (fill_en),
      .fill_data  (bus.apu_rdata_i),
      .fill_flags (bus.apu_rflags_i),
      .wb_en      (wb_fire),
      .flush_en   (flush_i),
      .count      (count),
      .inflight   (inflight),
      .head_entry (head_entry),
      .wb_valid   (wb_valid),
      .live       (live),
      .live_rd    (live_rd)
   );

   // Payload reads zero when nothing is offered.
   assign bus.wb_valid_o = wb_valid;
   assign bus.wb_rd_o    = wb_valid ? head_entry.rd    : '0;
   assign bus.wb_data_o  = wb_valid ? head_entry.data  : '0;
   assign bus.wb_flags_o = wb_valid ? head_entry.flags : '0;

`ifdef APU_DISPATCH_HAZARD_EN
   always_comb begin
      hazard = 1'b0;
      for (int j = 0; j < NRS; j++)
         for (int i = 0; i < DEPTH; i++)
            if (bus.issue_rs_use_i[j] && live[i] && (bus.issue_rs_i[j] == live_rd[i]))
               hazard = 1'b1;
   end
   assign unused_ok = head_entry.filled;
`else
   assign hazard    = 1'b0;
   assign unused_ok = ^{head_entry.filled, live, live_rd, bus.issue_rs_i, bus.issue_rs_use_i};
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= RUN;
         drop_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (flush_i && (net_inflight != '0)) begin
                  state    <= DRAIN;
                  drop_cnt <= net_inflight;
               end
            end
            DRAIN: begin
               if (bus.apu_rvalid_i) begin
                  drop_cnt <= drop_cnt - PW'(1);
                  if (drop_cnt == PW'(1)) state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // The FPU must never answer when nothing is outstanding.
   a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.apu_rvalid_i && (state == RUN) && (inflight == '0)));
endmodule

// File: doc/apu_dispatch.md
# apu_dispatch

Core-side APU initiator for the cv32e40p FPU path. It accepts FP operations from the core issue stage, drives the APU request channel (req/gnt) toward the FPU wrapper, and tracks in-flight operations in order. The FPU response channel has no backpressure and no ID, so the block reserves a buffer slot for every issued operation and returns each result to the register-file writeback port with its destination register.

## Interface
- DEPTH, 2: maximum operations issued but not yet written back (power of two, ≥2)
- NARGS, 3: operand count
- WOP, 8: op field width ({vec, op_mod, op[5:0]})
- NDSFLAGS, 15: downstream flags width ({int_fmt, src_fmt, dst_fmt, rnd_mode})
- NUSFLAGS, 5: FPU status flags width
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  discard all tracked operations
- issue_valid_i  in  1  core presents an operation
- issue_ready_o  out  1  operation accepted this cycle
- issue_operands_i  in  NARGS×32  operands
- issue_op_i  in  WOP  operation
- issue_flags_i  in  NDSFLAGS  formats / rounding mode
- issue_rd_i  in  5  destination register
- issue_rs_i  in  3×5  source registers
- issue_rs_use_i  in  3  source-valid mask
- apu_req_o  out  1  APU request
- apu_gnt_i  in  1  APU grant
- apu_operands_o / apu_op_o / apu_flags_o  out  NARGS×32 / WOP / NDSFLAGS  pass-through of the issue fields
- apu_rvalid_i  in  1  result valid (cannot be stalled)
- apu_rdata_i  in  32  result
- apu_rflags_i  in  NUSFLAGS  status
- wb_valid_o  out  1  result ready for writeback
- wb_ready_i  in  1  writeback accepted
- wb_rd_o / wb_data_o / wb_flags_o  out  5 / 32 / NUSFLAGS  writeback payload

## Operation
- Ring of DEPTH entries {rd, data, flags, filled}. Three pointers: alloc, fill, and head. Each pointer is log2(DEPTH)+1 bits and wraps naturally. The top bit distinguishes full from empty.
- Issue handshake = apu_req_o & apu_gnt_i. It writes rd at alloc and clears filled. alloc increments.
- apu_rvalid_i in RUN writes data/flags at fill, sets filled, and increments fill. Responses are strictly in order.
- Writeback handshake = wb_valid_o & wb_ready_i. head increments.
- can_accept = (state==RUN) & (alloc-head < DEPTH) & !hazard.
- apu_req_o = issue_valid_i & can_accept & !flush_i.
- issue_ready_o = apu_req_o & apu_gnt_i.
- FSM:
  - RUN → DRAIN on flush_i when in-flight count (alloc-fill, net of an rvalid in the same cycle) is nonzero. Otherwise stay in RUN.
  - On flush_i: head=fill=alloc, so all entries are dropped. drop_cnt loads the net in-flight count.
  - DRAIN: each apu_rvalid_i decrements drop_cnt and its result is discarded. No issue is allowed.
  - DRAIN → RUN when drop_cnt reaches 0 via an rvalid.
  - flush_i during DRAIN adds nothing, because no new issues occurred.
- Simultaneous events:
  - Issue, fill and writeback in the same cycle are all legal.
  - The count uses post-update pointers.
  - apu_rvalid_i with an empty in-flight set in RUN is a protocol error. It is ignored and flagged by an assertion.
- Reset mid-operation clears every pointer, drop_cnt and state=RUN. Late FPU responses after reset are the system's responsibility; the FPU is reset by the same reset.

## Timing
- Reset values: apu_req_o=0, issue_ready_o=0, wb_valid_o=0, wb_rd_o/wb_data_o/wb_flags_o=0, state=RUN, drop_cnt=0.
- issue_ready_o is combinational from apu_gnt_i. There is no issue latency.
- wb_valid_o is registered. A result received at cycle N appears at wb_valid_o at N+1 at the earliest. This holds when the entry is at head and earlier entries are retired.
- Writeback throughput is one per cycle under continuous wb_ready_i.
- wb payload is stable while wb_valid_o & !wb_ready_i.

## Configuration
- APU_DISPATCH_HAZARD_EN defined: hazard = OR over j of (issue_rs_use_i[j] & issue_rs_i[j] equals rd of any live entry between head and alloc). Issue stalls until that entry is written back.
- Undefined: hazard=0. issue_rs_i and issue_rs_use_i remain as ports and are ignored. The core is then responsible for RAW ordering.

## Structure
- apu_dispatch_pkg: entry_t struct {rd, data, flags, filled}, state_e {RUN, DRAIN}, and width constants matching the APU core package.
- One sub-module, apu_dispatch_ring: entry storage plus alloc/fill/head pointers and count.
- The top level holds the FSM, drop_cnt, the hazard compare and the handshakes.

## Test plan
- Single op: issue rd=5 with gnt the same cycle. rvalid data 0x3F800000 three cycles later → wb_valid_o the next cycle with rd=5, data 0x3F800000.
- DEPTH=2 with wb_ready_i=0: two issues succeed, and the third sees issue_ready_o=0 until one writeback completes.
- Back-to-back rvalid on consecutive cycles with wb_ready_i toggling → both results written back in issue order, with none lost.
- Flush with 2 in flight → DRAIN. Two later rvalids are discarded, no wb_valid_o occurs, and the block returns to RUN. A flush coincident with one rvalid → drop_cnt=1.
- Hazard (macro on): in-flight rd=7, next op with rs2=7 and use[1]=1 → issue stalls until rd=7 is written back. With the macro off → it issues immediately.
- rst_i asserted with 2 entries live → the next cycle shows outputs at reset values and an empty ring.
